// File: rtl/cpumc_pkg.sv
// ---------------------------------------------------------------------------
// cpumc_pkg
//
// Shared definitions for the CPU memory-controller responder slice.
//
// Contents:
//   state_t        - responder FSM states (2-bit encoding)
//   READ_LAT_MAX   - largest back-end read latency the counter can express
//   LAT_CNT_W      - width of the read-latency down-counter
//   REG_OAMDMA     - sprite DMA trigger register address
//   REG_OAMDATA    - sprite data port register address
//   lat_to_count() - clamps a latency parameter into the counter's legal range
// ---------------------------------------------------------------------------
package cpumc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int READ_LAT_MAX = 15;
    localparam int LAT_CNT_W    = 4;

    localparam logic [15:0] REG_OAMDMA  = 16'h4014;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;

    // An out-of-range latency would otherwise wrap the 4-bit counter and
    // either never complete or complete immediately; clamp it instead.
    function automatic logic [LAT_CNT_W-1:0] lat_to_count(input int lat);
        if (lat < 1) begin
            return LAT_CNT_W'(1);
        end else if (lat > READ_LAT_MAX) begin
            return LAT_CNT_W'(READ_LAT_MAX);
        end else begin
            return LAT_CNT_W'(lat);
        end
    endfunction

endpackage

// File: rtl/cpumc_wbuf.sv
// ---------------------------------------------------------------------------
// cpumc_wbuf
//
// One-entry posted-write buffer. Holds a single {address, data} pair that
// arrived while a read was outstanding, until the responder drains it.
//
// Ports:
//   clk_in    - system clock
//   rst_n_in  - synchronous active-low reset, empties the buffer
//   load_in   - capture addr_in/data_in and mark the entry full
//   clear_in  - mark the entry empty (after it has been written out)
//   addr_in   - write address to capture
//   data_in   - write data to capture
//   full_out  - entry holds a pending write
//   addr_out  - buffered address
//   data_out  - buffered data
// ---------------------------------------------------------------------------
module cpumc_wbuf #(
    parameter int ADDR_W = 11
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              load_in,
    input  logic              clear_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        data_in,
    output logic              full_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [7:0]        data_out
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    // A load in the same cycle as a clear refills the entry, so load wins.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (clear_in) begin
            full_d = 1'b0;
        end
        if (load_in) begin
            full_d = 1'b1;
            addr_d = addr_in;
            data_d = data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= 8'h00;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_out = full_q;
    assign addr_out = addr_q;
    assign data_out = data_q;

endmodule

// File: rtl/cpumc_rsp.sv
// ---------------------------------------------------------------------------
// cpumc_rsp
//
// Responder end of the CPU memory-controller request interface. Accepts
// single-cycle read requests and write strobes from the CPU core / sprite
// DMA, drives a synchronous RAM with a fixed read latency, returns read
// data behind a registered ready flag, and absorbs one posted write that
// arrives while a read is in flight.
//
// Parameters:
//   ADDR_W   - RAM address width; upper CPU address bits are ignored
//              (the RAM mirrors across the 16-bit space)
//   READ_LAT - cycles from mem_en_out to valid mem_d_in (1..15)
//
// Ports:
//   clk_in      - system clock
//   rst_n_in    - synchronous active-low reset
//   a_in        - request address
//   din_in      - write data
//   r_nw_in     - 1 = read/idle, 0 = write strobe (one cycle per write)
//   req_in      - read request pulse
//   rdy_out     - high when idle; dout_out holds the last completed read
//   dout_out    - registered read data
//   err_out     - sticky protocol-violation flag
//   mem_a_out   - back-end address
//   mem_d_out   - back-end write data
//   mem_en_out  - back-end read enable
//   mem_we_out  - back-end write enable
//   mem_d_in    - back-end read data
// ---------------------------------------------------------------------------
module cpumc_rsp
    import cpumc_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int READ_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [15:0]       a_in,
    input  logic [7:0]        din_in,
    input  logic              r_nw_in,
    input  logic              req_in,
    output logic              rdy_out,
    output logic [7:0]        dout_out,
    output logic              err_out,
    output logic [ADDR_W-1:0] mem_a_out,
    output logic [7:0]        mem_d_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    input  logic [7:0]        mem_d_in
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_to_count(READ_LAT);

    state_t                state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  rdy_q, rdy_d;
    logic [7:0]            dout_q, dout_d;
    logic                  err_q, err_d;

    logic                  wbuf_load;
    logic                  wbuf_clear;
    logic                  wbuf_full;
    logic [ADDR_W-1:0]     wbuf_addr;
    logic [7:0]            wbuf_data;

    logic                  wr_strobe;
    logic                  rd_done;

    assign wr_strobe = ~r_nw_in;

    // Upper address bits are deliberately ignored so the RAM mirrors.
    if (ADDR_W < 16) begin : g_mirror
        logic unused_addr_hi;
        assign unused_addr_hi = ^a_in[15:ADDR_W];
    end

    cpumc_wbuf #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load_in  (wbuf_load),
        .clear_in (wbuf_clear),
        .addr_in  (a_in[ADDR_W-1:0]),
        .data_in  (din_in),
        .full_out (wbuf_full),
        .addr_out (wbuf_addr),
        .data_out (wbuf_data)
    );

    // The counter is loaded with the latency on the request edge, so it
    // reads 1 in the cycle where mem_d_in becomes valid.
    assign rd_done = (cnt_q <= LAT_CNT_W'(1));

    // Next-state, register-next and back-end drive logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdy_d      = rdy_q;
        dout_d     = dout_q;
        err_d      = err_q;
        wbuf_load  = 1'b0;
        wbuf_clear = 1'b0;
        mem_en_out = 1'b0;
        mem_we_out = 1'b0;
        mem_a_out  = a_in[ADDR_W-1:0];
        mem_d_out  = din_in;

        case (state_q)
            S_IDLE: begin
                rdy_d = 1'b1;
                if (wr_strobe) begin
                    // A write wins over a simultaneous read request.
                    mem_we_out = 1'b1;
                    if (req_in) begin
                        err_d = 1'b1;
                    end
                end else if (req_in) begin
                    mem_en_out = 1'b1;
                    cnt_d      = LAT_LOAD;
                    rdy_d      = 1'b0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                rdy_d = 1'b0;
                cnt_d = cnt_q - LAT_CNT_W'(1);
                if (req_in) begin
                    err_d = 1'b1;
                end
                if (wr_strobe) begin
                    if (wbuf_full) begin
                        err_d = 1'b1;
                    end else begin
                        wbuf_load = 1'b1;
                    end
                end
                // A write landing in the final wait cycle still needs draining.
                if (rd_done) begin
                    dout_d = mem_d_in;
                    if (wbuf_full || wbuf_load) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                mem_we_out = 1'b1;
                mem_a_out  = wbuf_addr;
                mem_d_out  = wbuf_data;
                wbuf_clear = 1'b1;
                rdy_d      = 1'b1;
                state_d    = S_IDLE;
                if (wr_strobe || req_in) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // No back-end access may start while reset is asserted.
        if (!rst_n_in) begin
            mem_en_out = 1'b0;
            mem_we_out = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            dout_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign rdy_out  = rdy_q;
    assign dout_out = dout_q;
    assign err_out  = err_q;

endmodule

// File: doc/cpumc_rsp.md
Name: cpumc_rsp

Overview:
- Responder end of the CPU memory-controller request interface used by the sprite DMA engine and the CPU core.
- Accepts single-cycle read requests and write strobes, and drives a synchronous RAM back-end with fixed read latency.
- Returns read data with a registered ready handshake.
- Absorbs one posted write that arrives while a read is outstanding.

Parameters:
- ADDR_W, 11, RAM address width; the low ADDR_W bits of the CPU address select the word, and upper bits are ignored (mirroring).
- READ_LAT, 2, back-end read latency in cycles from mem_en_out to valid mem_d_in; legal range 1..15.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, synchronous, active-low
- a_in  input  16  request address
- din_in  input  8  write data
- r_nw_in  input  1  1 = read / idle, 0 = write strobe (one cycle per write)
- req_in  input  1  read request pulse, one cycle
- rdy_out  output  1  high = idle, dout_out valid for last completed read
- dout_out  output  8  read data, registered, held until next read completes
- err_out  output  1  sticky protocol-violation flag
- mem_a_out  output  ADDR_W  back-end address
- mem_d_out  output  8  back-end write data
- mem_en_out  output  1  back-end read enable
- mem_we_out  output  1  back-end write enable
- mem_d_in  input  8  back-end read data

Behaviour:
- Reset is synchronous, active-low, one clock, with rst_n_in sampled at the clock edge.
  - Register values after reset: state S_IDLE, rdy_out=1, dout_out=8'h00, err_out=0, write buffer empty, latency counter 0.
  - mem_en_out and mem_we_out are gated to 0 while rst_n_in=0.
  - Reset during S_WAIT or S_DRAIN aborts the access; any buffered write is discarded.
- States: S_IDLE, S_WAIT, S_DRAIN.
- S_IDLE, write (r_nw_in=0):
  - Combinationally drive mem_we_out=1, mem_a_out=a_in[ADDR_W-1:0], mem_d_out=din_in.
  - Stay in S_IDLE; rdy_out stays 1.
  - If req_in is also high, the write wins, req_in is ignored, and err_out is set.
- S_IDLE, read (req_in=1 with r_nw_in=1), sampled in cycle 0:
  - Combinationally drive mem_en_out=1 and mem_a_out=a_in[ADDR_W-1:0].
  - Load the counter with READ_LAT and go to S_WAIT; rdy_out=0 from cycle 1.
- S_WAIT:
  - Counter decrements each cycle.
  - In cycle READ_LAT, mem_d_in is captured into dout_out.
  - Next state: S_DRAIN if the write buffer is full, else S_IDLE.
  - Timing with an empty buffer: rdy_out=0 for cycles 1..READ_LAT, and rdy_out=1 with valid dout_out from cycle READ_LAT+1.
- S_WAIT, incoming write:
  - Write strobe with the buffer empty: capture {a_in[ADDR_W-1:0], din_in} into the one-entry buffer.
  - Write strobe with the buffer full: drop it and set err_out.
  - req_in in S_WAIT: ignore it and set err_out.
- S_DRAIN, exactly one cycle:
  - Drive mem_we_out=1 with the buffered address and data; clear the buffer.
  - rdy_out stays 0; go to S_IDLE.
  - rdy_out=1 from cycle READ_LAT+2.
  - Write or req_in arriving during S_DRAIN: set err_out and drop the transaction.
- mem_en_out and mem_we_out are never both 1 in the same cycle.
- err_out is sticky; it clears only on reset.
- dout_out changes only at read completion; writes never modify it.

Decomposition:
- Shared package cpumc_pkg holds:
  - the state encodings S_IDLE/S_WAIT/S_DRAIN as 2-bit constants;
  - the shared register-address constants, e.g. 16'h4014 and 16'h2004;
  - READ_LAT_MAX = 15.
- One sub-module, cpumc_wbuf: a one-entry posted-write buffer.
  - Inputs: load, addr, data, clear.
  - Outputs: full, addr, data.
  - Reset: synchronous, active-low.

Test Plan:
- Read after reset: load RAM[16'h0123]=8'h5A and set READ_LAT=2, then pulse req_in with a_in=16'h0123 -> mem_en_out=1 in cycle 0 with mem_a_out=11'h123; rdy_out=0 in cycles 1–2; rdy_out=1 and dout_out=8'h5A in cycle 3.
- Mirroring: write 8'hC3 to a_in=16'h0805, then read 16'h0005 -> dout_out=8'hC3; rdy_out stays 1 throughout the write.
- Write during read: req_in to 16'h0010, then a write of 8'h77 to 16'h0011 in cycle 1 -> mem_we_out pulses in cycle READ_LAT+1 with addr 11'h011; rdy_out rises in cycle READ_LAT+2; a subsequent read of 16'h0011 returns 8'h77.
- Protocol violations: req_in in cycle 1 of a read, and two writes during one read -> err_out=1 and stays 1; the second write is not performed; dout_out holds the first read's data.
- DMA-style burst: 256 sequences of {req_in to 16'h0200+i, wait for rdy_out, write to 16'h2004} -> every returned byte matches the RAM preload, and no err_out.
- Reset mid-read: drop rst_n_in for one cycle in cycle 1 of a read with a buffered write -> next cycle rdy_out=1, dout_out=8'h00, the buffered write is never issued, and mem_en_out/mem_we_out are 0 during reset.
